mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side end of the proc2mem/mem2proc bus used by icache. Accepts BUS_LOAD/BUS_STORE
//  with a combinational 4-bit response tag (0 = refused), services it against an internal
//  64-bit-word array, and returns {tag,data} exactly LATENCY cycles later. Synthesizable
//  bus model for the I-side fetch path and its testbenches.
// PARAMETERS
//  LATENCY          4   cycles from acceptance to tag/data return; legal 1..15
//  ACCEPT_INTERVAL  1   min cycles between acceptances (1 = every cycle); legal 1..16
//  MEM_IDX_BITS     12  log2(words in backing array)
// PORTS
//  clock             in   1   sole clock, rising edge
//  reset             in   1   asynchronous, active-high
//  proc2mem_command  in   2   BUS_NONE / BUS_LOAD / BUS_STORE
//  proc2mem_addr     in   64  byte address; word index = addr[3+MEM_IDX_BITS-1:3]
//  proc2mem_data     in   64  store data, sampled with a BUS_STORE
//  mem2proc_response out  4   comb.: allocated tag if accepted this cycle, else 0
//  mem2proc_data     out  64  registered return data, valid with nonzero mem2proc_tag
//  mem2proc_tag      out  4   registered; nonzero = transaction with this tag completes now
// BEHAVIOUR
//  - Reset (async): mem2proc_tag=0, mem2proc_data=0, pipeline valids cleared, tags 1..15
//    free, interval counter 0. Array contents NOT reset. response=0 while reset high.
//  - accept = cmd in {LOAD,STORE} & any free tag & interval_cnt==0 & !reset.
//    response = accept ? lowest-numbered free tag : 0. Tag 0 never allocated.
//  - Index wraps: addr bits above index and addr[2:0] ignored.
//  - On accepting edge (cycle T): tag marked busy; STORE writes array[idx]<=data; LOAD
//    reads array[idx] (post-write order irrelevant: one cmd/cycle). Entry {tag,data} enters
//    stage 0 of a LATENCY-deep shift pipe; STORE carries written data.
//  - Return: last stage drives mem2proc_tag/data during cycle T+LATENCY; no return stage
//    -> tag=0, data=0. At most one return per cycle; order = acceptance order.
//  - Tag freed on edge ending its return cycle; allocatable from T+LATENCY+1.
//    Same-cycle return + accept: returning tag not yet eligible.
//  - Interval: on accept, interval_cnt<=ACCEPT_INTERVAL-1; decrements to 0 otherwise.
//  - Tag exhaustion (only when LATENCY>=15 pipeline is full): refuse (response 0) until a
//    return frees one; refused requests leave no state.
//  - BUS_NONE / refused cmd: no array write, no pipe entry.
//  - Load-after-store same index, consecutive accepts: load returns new data.
//  - Reset mid-flight: all pending returns discarded; no spurious tag after deassert.
// STRUCTURE
//  - Shared package/defines: BUS_NONE/BUS_LOAD/BUS_STORE encodings, MEM_TAG_BITS=4,
//    `SD delay; reuse existing bus header, no local copies.
//  - Sub-module mem_tag_alloc: 15-bit free mask, lowest-free priority encoder (comb.
//    alloc_tag, any_free), alloc/free ports, async reset to all-free.
//  - Top: array, LATENCY-stage pipe {valid,tag[3:0],data[63:0]}, interval counter.
// TESTING
//  - Reset: hold reset 3 cyc w/ BUS_LOAD asserted -> response=0, tag=0; first cmd after
//    deassert gets response=1.
//  - STORE 0x1000 data 64'hCAFE then LOAD 0x1000 next cycle (LATENCY=4) -> responses 1,2;
//    tag 1 data CAFE at T+4, tag 2 data CAFE at T+5.
//  - Back-to-back 20 LOADs, LATENCY=4 -> responses cycle 1..5 then reuse 1 once freed;
//    every tag returns exactly 4 cycles after its response.
//  - ACCEPT_INTERVAL=3, LOAD held 9 cycles -> nonzero response only cycles 0,3,6.
//  - LATENCY=15, continuous LOADs -> tags 1..15 then response=0 one cycle, tag 1 reused
//    the cycle after its return.
//  - Async reset pulse mid-cycle with 3 loads in flight -> tag drops to 0 immediately,
//    no returns afterward, next accept gets tag 1.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared bus encodings, tag geometry and pipeline entry type for the memory responder.
// The tag helper turns a nonzero tag number into its bit in the 15-entry free mask.
package mem_responder_pkg;

   localparam int MEM_TAG_BITS = 4;
   localparam int NUM_TAGS     = 15;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } bus_command_t;

   typedef struct packed {
      logic                    valid;
      logic [MEM_TAG_BITS-1:0] tag;
      logic [63:0]             data;
   } pipe_entry_t;

   function automatic logic is_bus_request(input logic [1:0] cmd);
      return (cmd == BUS_LOAD) || (cmd == BUS_STORE);
   endfunction

   // Tag n lives at mask bit n-1; tag 0 has no bit.
   function automatic logic [NUM_TAGS-1:0] tag_to_bit(input logic [MEM_TAG_BITS-1:0] tag);
      logic [NUM_TAGS-1:0] b;
      b = {NUM_TAGS{1'b0}};
      if (tag != 4'd0) begin
         b[tag - 4'd1] = 1'b1;
      end else begin
         b = {NUM_TAGS{1'b0}};
      end
      return b;
   endfunction

endpackage

// File: rtl/mem_tag_alloc.sv
// Response-tag allocator: 15-entry free mask, lowest free tag offered combinationally.
// A tag freed on an edge only becomes eligible in the following cycle.
module mem_tag_alloc
   import mem_responder_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    alloc,
   input  logic                    free_en,
   input  logic [MEM_TAG_BITS-1:0] free_tag,
   output logic [MEM_TAG_BITS-1:0] alloc_tag,
   output logic                    any_free
);

   logic [NUM_TAGS-1:0] free_mask;
   logic [NUM_TAGS-1:0] alloc_bit;
   logic [NUM_TAGS-1:0] free_bit;

   // Priority encoder: scanning downward leaves the lowest set bit's tag.
   always_comb begin
      alloc_tag = 4'd0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         alloc_tag = free_mask[i] ? 4'(i + 1) : alloc_tag;
      end
   end

   assign any_free  = |free_mask;
   assign alloc_bit = alloc   ? tag_to_bit(alloc_tag) : {NUM_TAGS{1'b0}};
   assign free_bit  = free_en ? tag_to_bit(free_tag)  : {NUM_TAGS{1'b0}};

   // Free mask update; alloc and free never name the same tag in one cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         free_mask <= {NUM_TAGS{1'b1}};
      end else begin
         free_mask <= (free_mask & ~alloc_bit) | free_bit;
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: accepts LOAD/STORE with a combinational tag, services the
// request against a word array and returns {tag,data} exactly LATENCY cycles later.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int LATENCY         = 4,
   parameter int ACCEPT_INTERVAL = 1,
   parameter int MEM_IDX_BITS    = 12
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  proc2mem_command,
   input  logic [63:0] proc2mem_addr,
   input  logic [63:0] proc2mem_data,
   output logic [3:0]  mem2proc_response,
   output logic [63:0] mem2proc_data,
   output logic [3:0]  mem2proc_tag
);

   localparam int          DEPTH           = 1 << MEM_IDX_BITS;
   localparam logic [3:0]  INTERVAL_RELOAD = 4'(ACCEPT_INTERVAL - 1);

   logic [63:0]             mem [DEPTH];
   logic [MEM_IDX_BITS-1:0] idx;
   logic                    addr_unused;
   pipe_entry_t             pipe [LATENCY];
   pipe_entry_t             issue;
   pipe_entry_t             ret;
   logic [3:0]              interval_cnt;
   logic [3:0]              alloc_tag;
   logic                    any_free;
   logic                    accept;
   logic                    is_store;

   assign idx         = proc2mem_addr[3+MEM_IDX_BITS-1:3];
   assign addr_unused = ^{proc2mem_addr[63:3+MEM_IDX_BITS], proc2mem_addr[2:0]};
   assign is_store    = (proc2mem_command == BUS_STORE);
   assign accept      = is_bus_request(proc2mem_command) & any_free &
                        (interval_cnt == 4'd0) & ~reset;
   assign ret         = pipe[LATENCY-1];

   mem_tag_alloc u_tag_alloc (
      .clock     (clock),
      .reset     (reset),
      .alloc     (accept),
      .free_en   (ret.valid),
      .free_tag  (ret.tag),
      .alloc_tag (alloc_tag),
      .any_free  (any_free)
   );

   assign mem2proc_response = accept ? alloc_tag : 4'd0;

   // A store returns the data it wrote, so the array read is bypassed for it.
   always_comb begin
      issue.valid = 1'b1;
      issue.tag   = alloc_tag;
      issue.data  = is_store ? proc2mem_data : mem[idx];
   end

   // Backing array is deliberately not reset.
   always_ff @(posedge clock) begin
      if (accept && is_store) begin
         mem[idx] <= proc2mem_data;
      end
   end

   // Return pipe; empty slots hold all-zero so the last stage drives the outputs directly.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe[i] <= '0;
         end
      end else begin
         pipe[0] <= accept ? issue : '0;
         for (int i = 1; i < LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   // Minimum spacing between acceptances.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         interval_cnt <= 4'd0;
      end else if (accept) begin
         interval_cnt <= INTERVAL_RELOAD;
      end else if (interval_cnt != 4'd0) begin
         interval_cnt <= interval_cnt - 4'd1;
      end else begin
         interval_cnt <= 4'd0;
      end
   end

   assign mem2proc_tag  = ret.tag;
   assign mem2proc_data = ret.data;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three configurations checked cycle by cycle against a
// transaction-level model (free-tag set, time-stamped return queue, sparse memory).
module tb_mem_responder;
   import mem_responder_pkg::*;

   typedef struct {
      int          due;
      logic [3:0]  tag;
      logic [63:0] data;
      bit          known;
   } ent_t;

   logic        clock;
   logic        reset;
   logic [1:0]  cmd   [3];
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [3:0]  resp  [3];
   logic [3:0]  rtag  [3];
   logic [63:0] rdata [3];

   int lat [3] = '{4, 15, 4};
   int ivl [3] = '{1, 1, 3};

   int          n_vec;
   int          n_err;
   int          act;
   int          cyc;
   int          icnt;
   bit          free_m [16];
   ent_t        q [$];
   logic [63:0] mdl_mem [int];
   bit          last_acc;

   mem_responder #(.LATENCY(4), .ACCEPT_INTERVAL(1), .MEM_IDX_BITS(12)) u_dut_a (
      .clock(clock), .reset(reset), .proc2mem_command(cmd[0]), .proc2mem_addr(addr),
      .proc2mem_data(wdata), .mem2proc_response(resp[0]), .mem2proc_data(rdata[0]),
      .mem2proc_tag(rtag[0]));

   mem_responder #(.LATENCY(15), .ACCEPT_INTERVAL(1), .MEM_IDX_BITS(12)) u_dut_b (
      .clock(clock), .reset(reset), .proc2mem_command(cmd[1]), .proc2mem_addr(addr),
      .proc2mem_data(wdata), .mem2proc_response(resp[1]), .mem2proc_data(rdata[1]),
      .mem2proc_tag(rtag[1]));

   mem_responder #(.LATENCY(4), .ACCEPT_INTERVAL(3), .MEM_IDX_BITS(12)) u_dut_c (
      .clock(clock), .reset(reset), .proc2mem_command(cmd[2]), .proc2mem_addr(addr),
      .proc2mem_data(wdata), .mem2proc_response(resp[2]), .mem2proc_data(rdata[2]),
      .mem2proc_tag(rtag[2]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s (dut %0d, cycle %0d): got %h expected %h", name, act, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      for (int t = 0; t < 16; t++) free_m[t] = (t != 0);
      icnt = 0;
      cyc  = 0;
   endtask

   function automatic logic [63:0] addr_of(input int i);
      logic [63:0] a;
      logic [11:0] w;
      a = {$urandom(), $urandom()};
      w = 12'(i * 37 + 5);
      a[14:3] = w;
      return a;
   endfunction

   // One bus cycle: drive, then check the model's expectations, then advance the model.
   task automatic step(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d);
      ent_t        e;
      logic [3:0]  exp_resp;
      logic [3:0]  exp_tag;
      logic [63:0] exp_data;
      bit          known;
      int          lo;
      int          key;
      @(negedge clock);
      for (int k = 0; k < 3; k++) cmd[k] = (k == act) ? c : BUS_NONE;
      addr  = a;
      wdata = d;
      #1;
      exp_tag  = 4'd0;
      exp_data = 64'd0;
      known    = 1'b1;
      if (q.size() > 0 && q[0].due == cyc) begin
         exp_tag  = q[0].tag;
         exp_data = q[0].data;
         known    = q[0].known;
      end
      lo = 0;
      for (int t = 15; t >= 1; t--) if (free_m[t]) lo = t;
      exp_resp = 4'd0;
      if ((c == BUS_LOAD || c == BUS_STORE) && lo != 0 && icnt == 0) exp_resp = lo[3:0];
      chk("response", resp[act], exp_resp);
      chk("ret_tag", rtag[act], exp_tag);
      if (known) chk("ret_data", rdata[act], exp_data);
      if (exp_tag != 4'd0) begin
         void'(q.pop_front());
         free_m[exp_tag] = 1'b1;
      end
      last_acc = (exp_resp != 4'd0);
      if (last_acc) begin
         key       = act * 4096 + int'(a[14:3]);
         free_m[lo] = 1'b0;
         e.due     = cyc + lat[act];
         e.tag     = exp_resp;
         if (c == BUS_STORE) begin
            mdl_mem[key] = d;
            e.data  = d;
            e.known = 1'b1;
         end else begin
            e.known = mdl_mem.exists(key);
            e.data  = e.known ? mdl_mem[key] : 64'd0;
         end
         q.push_back(e);
         icnt = ivl[act] - 1;
      end else if (icnt > 0) begin
         icnt--;
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(BUS_NONE, 64'd0, 64'd0);
   endtask

   task automatic preload();
      for (int i = 0; i < 16; i++) begin
         logic [63:0] a;
         logic [63:0] d;
         a = addr_of(i);
         d = {$urandom(), $urandom()};
         for (int tries = 0; tries < 20; tries++) begin
            step(BUS_STORE, a, d);
            if (last_acc) break;
         end
      end
   endtask

   task automatic random_traffic(input int n);
      for (int i = 0; i < n; i++) begin
         int r;
         logic [1:0] c;
         r = $urandom_range(0, 7);
         c = (r < 2) ? BUS_NONE : (r < 5) ? BUS_LOAD : BUS_STORE;
         step(c, addr_of($urandom_range(0, 15)), {$urandom(), $urandom()});
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      act   = 0;
      addr  = 64'd0;
      wdata = 64'd0;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) cmd[k] = BUS_LOAD;
      model_reset();

      // Reset held with LOAD requested: nothing accepted, nothing returned.
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         #1;
         for (int k = 0; k < 3; k++) begin
            chk("reset_resp", resp[k], 64'd0);
            chk("reset_tag", rtag[k], 64'd0);
         end
      end
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) cmd[k] = BUS_NONE;

      // Configuration A: LATENCY 4, accept every cycle.
      act = 0;
      model_reset();
      step(BUS_STORE, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_CAFE);
      step(BUS_LOAD,  64'h0000_0000_0000_1000, 64'd0);
      idle(6);
      for (int i = 0; i < 20; i++) step(BUS_LOAD, 64'hABCD_0000_0000_1005, 64'd0);
      idle(6);
      preload();
      random_traffic(200);
      idle(6);

      // Mid-flight asynchronous reset with three loads outstanding.
      for (int i = 0; i < 3; i++) step(BUS_LOAD, addr_of(i), 64'd0);
      step(BUS_NONE, 64'd0, 64'd0);
      @(posedge clock);
      #2;
      chk("pre_reset_tag", rtag[0], (q.size() > 0) ? 64'(q[0].tag) : 64'd0);
      cmd[0] = BUS_LOAD;
      reset  = 1'b1;
      #1;
      chk("async_reset_tag", rtag[0], 64'd0);
      chk("async_reset_data", rdata[0], 64'd0);
      chk("async_reset_resp", resp[0], 64'd0);
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) cmd[k] = BUS_NONE;
      model_reset();
      idle(6);
      step(BUS_LOAD, addr_of(1), 64'd0);
      idle(6);

      // Configuration B: LATENCY 15, tag exhaustion under continuous loads.
      act = 1;
      model_reset();
      preload();
      idle(17);
      for (int i = 0; i < 40; i++) step(BUS_LOAD, addr_of($urandom_range(0, 15)), 64'd0);
      idle(17);
      random_traffic(200);
      idle(17);

      // Configuration C: ACCEPT_INTERVAL 3.
      act = 2;
      model_reset();
      preload();
      idle(6);
      for (int i = 0; i < 9; i++) step(BUS_LOAD, addr_of(i), 64'd0);
      idle(6);
      random_traffic(150);
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
